// File: rtl/sprite_pkg.sv
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared constants, sprite slot / FSM encodings and base-address
//                helper for the sprite row writer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

    localparam int ROWS        = 32;
    localparam int NUM_SPRITES = 6;
    localparam int ADDR_W      = 8;

    typedef enum logic [2:0] {
        TANK_D0 = 3'd0,
        TANK_D1 = 3'd1,
        TANK_D2 = 3'd2,
        TANK_D3 = 3'd3,
        BULLET  = 3'd4,
        BRICK   = 3'd5
    } sprite_id_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_RDREQ   = 3'd3,
        S_CMP     = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    function automatic int unsigned sprite_base(input logic [2:0] id,
                                                input int unsigned rows = ROWS);
        return 32'(id) * rows;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_row_packer.sv
// ============================================================================
//  Module      : sprite_row_packer
//  Description : Shifts stream bytes into a 32-bit row word, first byte ending
//                up in bits [31:24]; flags the transfer that completes a row.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_row_packer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        row_full
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            r_word <= 32'd0;
            r_cnt  <= 2'd0;
        end else if (shift) begin
            r_word <= {r_word[23:0], in_data};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    // The 2-bit count wraps to zero on the fourth byte, so each row starts clean.
    assign word     = r_word;
    assign row_full = shift && (r_cnt == 2'd3);

endmodule

`default_nettype wire

// File: rtl/sprite_row_writer.sv
// ============================================================================
//  Module      : sprite_row_writer
//  Description : Packs a 4-bytes-per-row sprite byte stream into 32-bit rows
//                and writes them to sprite memory. Optional read-back check
//                enabled by defining SPRITE_VERIFY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_row_writer #(
    parameter int NUM_SPRITES = sprite_pkg::NUM_SPRITES,
    parameter int ROWS        = sprite_pkg::ROWS,
    parameter int ADDR_W      = sprite_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [2:0]        sprite_id,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef SPRITE_VERIFY_EN
    ,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              mismatch
`endif
);

    import sprite_pkg::*;

    localparam int              ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(ROWS - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_last_addr;
    logic [31:0]       r_last_data;
    logic [ROW_W-1:0]  r_row;
    logic              r_err;

    logic [ADDR_W-1:0] w_cur_addr;
    logic [31:0]       w_word;
    logic              w_row_full;
    logic              w_xfer;
    logic              w_id_ok;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_row_end;
    logic              w_last_row;

    assign w_id_ok     = 32'(sprite_id) < $unsigned(NUM_SPRITES);
    assign w_start_ok  = (r_state == S_IDLE) && start && w_id_ok;
    assign w_start_bad = (r_state == S_IDLE) && start && !w_id_ok;
    assign w_xfer      = (r_state == S_COLLECT) && in_valid;
    assign w_cur_addr  = r_base + ADDR_W'(r_row);
    assign w_last_row  = (r_row == c_LAST_ROW);

    // The row is retired after its last per-row state: WRITE, or CMP with read-back.
`ifdef SPRITE_VERIFY_EN
    assign w_row_end = (r_state == S_CMP);
`else
    assign w_row_end = (r_state == S_WRITE);
`endif

    sprite_row_packer u_packer (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear    (w_start_ok),
        .shift    (w_xfer),
        .in_data  (in_data),
        .word     (w_word),
        .row_full (w_row_full)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_base      <= '0;
            r_row       <= '0;
            r_last_addr <= '0;
            r_last_data <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_start_bad;
            if (w_start_ok) begin
                r_base <= ADDR_W'(sprite_base(sprite_id, $unsigned(ROWS)));
                r_row  <= '0;
            end else if (w_row_end && !w_last_row) begin
                r_row <= r_row + ROW_W'(1);
            end
            if (r_state == S_WRITE) begin
                r_last_addr <= w_cur_addr;
                r_last_data <= w_word;
            end
        end
    end

`ifdef SPRITE_VERIFY_EN
    logic r_mismatch;

    always_ff @(posedge Clk) begin
        if (Reset || w_start_ok) begin
            r_mismatch <= 1'b0;
        end else if ((r_state == S_CMP) && (rd_data != r_last_data)) begin
            r_mismatch <= 1'b1;
        end
    end

    assign rd_addr  = r_last_addr;
    assign mismatch = r_mismatch;
`endif

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = r_last_addr;
        wr_data     = r_last_data;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        err         = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                if (w_row_full) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                // Present the fresh row directly; the hold registers catch up next cycle.
                wr_en   = 1'b1;
                wr_addr = w_cur_addr;
                wr_data = w_word;
`ifdef SPRITE_VERIFY_EN
                w_state_nxt = S_RDREQ;
`else
                w_state_nxt = w_last_row ? S_DONE : S_COLLECT;
`endif
            end
            S_RDREQ: begin
                w_state_nxt = S_CMP;
            end
            S_CMP: begin
                w_state_nxt = w_last_row ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_row_writer.sv
// ============================================================================
//  Module      : tb_sprite_row_writer
//  Description : Self-checking bench for sprite_row_writer against a row/address
//                reference computed from the bytes sent.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_row_writer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  sprite_id = 3'd0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
`ifdef SPRITE_VERIFY_EN
    logic [7:0]  rd_addr;
    logic [31:0] rd_data = 32'd0;
    logic        mismatch;
    logic [31:0] mem [0:255];
`endif

    sprite_row_writer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .sprite_id (sprite_id),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef SPRITE_VERIFY_EN
        ,
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .mismatch  (mismatch)
`endif
    );

    always #5 Clk = ~Clk;

`ifdef SPRITE_VERIFY_EN
    localparam int ROW_CYC = 7;
    // Memory model with one-cycle read latency; address 97 reads back corrupted.
    always @(posedge Clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= (rd_addr == 8'd97) ? ~mem[rd_addr] : mem[rd_addr];
    end
`else
    localparam int ROW_CYC = 5;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  tx [$];
    logic [39:0] wq [$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int busy_cyc = 0;
    int overlap  = 0;

    always @(negedge Clk) begin
        if (!Reset) begin
            if (wr_en) wq.push_back({wr_addr, wr_data});
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (busy) busy_cyc++;
            if (wr_en && in_ready) overlap++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic gen_bytes(input int n, input bit rnd, input logic [7:0] fill);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(rnd ? 8'($urandom) : fill);
    endtask

    task automatic do_start(input logic [2:0] id);
        @(posedge Clk); #1;
        start = 1'b1;
        sprite_id = id;
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    task automatic send_bytes(input int first, input int count, input int gap_pct);
        bit acc;
        for (int i = first; i < first + count; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge Clk); #1;
            end
            in_valid = 1'b1;
            in_data  = tx[i];
            acc = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) begin
                @(negedge Clk);
                acc = in_ready;
                @(posedge Clk); #1;
            end
            if (!acc) begin
                n_vec++; n_err++;
                $display("FAIL handshake byte %0d: in_ready=0 after 40 cycles, required 1", i);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int t = 0; t < 20 && busy; t++) begin
            @(posedge Clk); #1;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle: busy=%b, required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_vec++;
        if ({in_ready, wr_en, busy, done, err} !== 5'b0 || wr_addr !== 8'd0 || wr_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset outputs: rdy/wen/busy/done/err=%b addr=%0d data=%h, required all 0",
                     {in_ready, wr_en, busy, done, err}, wr_addr, wr_data);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        n_vec++;
        if ({in_ready, wr_en, busy} !== 3'b0) begin
            n_err++;
            $display("FAIL post-reset idle: rdy/wen/busy=%b, required 000", {in_ready, wr_en, busy});
        end
    endtask

    task automatic test_full_load();
        int w0, d0, b0;
        gen_bytes(128, 1'b0, 8'hA5);
        w0 = wq.size(); d0 = done_cnt; b0 = busy_cyc;
        do_start(3'd0);
        send_bytes(0, 128, 0);
        wait_idle("t1");
        n_vec++;
        if (wq.size() - w0 != 32) begin
            n_err++;
            $display("FAIL t1 write count: got %0d, required 32", wq.size() - w0);
        end
        for (int r = 0; r < 32 && w0 + r < wq.size(); r++) begin
            n_vec++;
            if (wq[w0 + r] !== {8'(r), 32'hA5A5A5A5}) begin
                n_err++;
                $display("FAIL t1 row %0d: got addr=%0d data=%h, required addr=%0d data=a5a5a5a5",
                         r, wq[w0 + r][39:32], wq[w0 + r][31:0], r);
            end
        end
        n_vec++;
        if (done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL t1 done pulses: got %0d, required 1", done_cnt - d0);
        end
        n_vec++;
        if (busy_cyc - b0 != 32 * ROW_CYC + 1) begin
            n_err++;
            $display("FAIL t1 busy cycles: got %0d, required %0d", busy_cyc - b0, 32 * ROW_CYC + 1);
        end
    endtask

    task automatic test_first_row_latency();
        gen_bytes(128, 1'b1, 8'h00);
        tx[0] = 8'h00; tx[1] = 8'h01; tx[2] = 8'h02; tx[3] = 8'h03;
        do_start(3'd5);
        send_bytes(0, 4, 0);
        @(negedge Clk);
        n_vec++;
        if (wr_en !== 1'b1 || wr_addr !== 8'd160 || wr_data !== 32'h00010203) begin
            n_err++;
            $display("FAIL t2 first write: wen=%b addr=%0d data=%h, required 1 160 00010203",
                     wr_en, wr_addr, wr_data);
        end
        @(posedge Clk); #1;
        send_bytes(4, 124, 0);
        wait_idle("t2");
        @(negedge Clk);
        n_vec++;
        if (wr_addr !== 8'd191 || wr_data !== {tx[124], tx[125], tx[126], tx[127]}) begin
            n_err++;
            $display("FAIL t2 hold: addr=%0d data=%h, required 191 %h",
                     wr_addr, wr_data, {tx[124], tx[125], tx[126], tx[127]});
        end
    endtask

    task automatic test_gapped_load();
        int w0, o0;
        logic [39:0] exp_w;
        gen_bytes(128, 1'b1, 8'h00);
        w0 = wq.size(); o0 = overlap;
        do_start(3'd4);
        send_bytes(0, 128, 40);
        wait_idle("t3");
        n_vec++;
        if (wq.size() - w0 != 32) begin
            n_err++;
            $display("FAIL t3 write count: got %0d, required 32", wq.size() - w0);
        end
        for (int r = 0; r < 32 && w0 + r < wq.size(); r++) begin
            exp_w = {8'(128 + r), tx[4*r], tx[4*r+1], tx[4*r+2], tx[4*r+3]};
            n_vec++;
            if (wq[w0 + r] !== exp_w) begin
                n_err++;
                $display("FAIL t3 row %0d: got %h, required %h", r, wq[w0 + r], exp_w);
            end
        end
        n_vec++;
        if (overlap != o0) begin
            n_err++;
            $display("FAIL t3 in_ready during write: got %0d cycles, required 0", overlap - o0);
        end
    endtask

    task automatic test_bad_id();
        int w0, e0;
        for (int k = 6; k < 8; k++) begin
            w0 = wq.size(); e0 = err_cnt;
            do_start(3'(k));
            @(negedge Clk);
            n_vec++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL t4 id=%0d err cycle: err=%b busy=%b, required 1 0", k, err, busy);
            end
            repeat (4) @(negedge Clk);
            n_vec++;
            if (err_cnt - e0 != 1 || wq.size() != w0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL t4 id=%0d: err pulses=%0d writes=%0d busy=%b, required 1 0 0",
                         k, err_cnt - e0, wq.size() - w0, busy);
            end
        end
    endtask

    task automatic test_reset_midload();
        int w0;
        logic [39:0] exp_w;
        gen_bytes(128, 1'b1, 8'h00);
        w0 = wq.size();
        do_start(3'd2);
        send_bytes(0, 42, 20);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        Reset = 1'b1;
        @(posedge Clk); #1;
        @(negedge Clk);
        n_vec++;
        if ({in_ready, wr_en, busy, done, err} !== 5'b0 || wr_addr !== 8'd0 || wr_data !== 32'd0) begin
            n_err++;
            $display("FAIL t5 reset outputs: rdy/wen/busy/done/err=%b addr=%0d data=%h, required all 0",
                     {in_ready, wr_en, busy, done, err}, wr_addr, wr_data);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        in_valid = 1'b0;
        n_vec++;
        if (wq.size() - w0 != 10 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL t5 aborted load: writes=%0d busy=%b, required 10 0", wq.size() - w0, busy);
        end
        for (int r = 0; r < 10 && w0 + r < wq.size(); r++) begin
            exp_w = {8'(64 + r), tx[4*r], tx[4*r+1], tx[4*r+2], tx[4*r+3]};
            n_vec++;
            if (wq[w0 + r] !== exp_w) begin
                n_err++;
                $display("FAIL t5 pre-reset row %0d: got %h, required %h", r, wq[w0 + r], exp_w);
            end
        end
        gen_bytes(128, 1'b1, 8'h00);
        w0 = wq.size();
        do_start(3'd2);
        send_bytes(0, 128, 10);
        wait_idle("t5");
        n_vec++;
        if (wq.size() - w0 != 32) begin
            n_err++;
            $display("FAIL t5 reload count: got %0d, required 32", wq.size() - w0);
        end
        for (int r = 0; r < 32 && w0 + r < wq.size(); r++) begin
            exp_w = {8'(64 + r), tx[4*r], tx[4*r+1], tx[4*r+2], tx[4*r+3]};
            n_vec++;
            if (wq[w0 + r] !== exp_w) begin
                n_err++;
                $display("FAIL t5 reload row %0d: got %h, required %h", r, wq[w0 + r], exp_w);
            end
        end
    endtask

`ifdef SPRITE_VERIFY_EN
    task automatic test_verify();
        gen_bytes(128, 1'b1, 8'h00);
        do_start(3'd3);
        send_bytes(0, 4, 0);
        repeat (3) @(negedge Clk);
        n_vec++;
        if (mismatch !== 1'b0) begin
            n_err++;
            $display("FAIL t6 row0 mismatch: got %b, required 0", mismatch);
        end
        send_bytes(4, 124, 0);
        wait_idle("t6");
        n_vec++;
        if (mismatch !== 1'b1) begin
            n_err++;
            $display("FAIL t6 sticky mismatch: got %b, required 1", mismatch);
        end
        do_start(3'd0);
        @(negedge Clk);
        n_vec++;
        if (mismatch !== 1'b0) begin
            n_err++;
            $display("FAIL t6 clear on start: got %b, required 0", mismatch);
        end
        send_bytes(0, 128, 0);
        wait_idle("t6b");
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_first_row_latency();
        test_gapped_load();
        test_bad_id();
        test_reset_midload();
`ifdef SPRITE_VERIFY_EN
        test_verify();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
